div_sequencer: RTL and testbench
================================

Name: div_sequencer

Overview:
- Multi-cycle RV32M divide unit and its sequencing FSM, placed in the execute stage beside the ALU operand/next-PC selection.
- Accepts DIV/DIVU/REM/REMU with operands already selected from rs1/rs2.
- Computes the result with a radix-2 restoring iteration.
- Holds the pipeline via a stall output until the result is ready, and aborts on pipeline flush.

Parameters:
XLEN, 32, operand/result width; iteration count equals XLEN.
FAST_PATH_EN, 1, when 1, divide-by-zero and signed overflow complete without iterating.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  reset; synchronous, active-high.
req_valid  input  1  divide request present in execute.
req_ready  output  1  unit can accept a request; high only in IDLE.
op  input  2  DivOp: DIV=00, DIVU=01, REM=10, REMU=11.
dividend  input  XLEN  rs1 value.
divisor  input  XLEN  rs2 value.
flush  input  1  pipeline kill (branch redirect or trap).
stall  output  1  freezes upstream stages while the divide is in progress.
resp_valid  output  1  one-cycle pulse; result is valid.
result  output  XLEN  quotient or remainder; held until the next acceptance.

Behaviour:
- States: IDLE, CALC, FIX, DONE.
- Accept condition: state==IDLE && req_valid && !flush. op and operands are latched at acceptance.
- Cycle numbering: the acceptance cycle is cycle 0.
- Normal path: CALC occupies cycles 1..32 (5-bit counter 0..31), FIX is cycle 33, DONE is cycle 34 with resp_valid=1. Next state after DONE is IDLE, so the next acceptance is possible in cycle 35.
- Fast path (FAST_PATH_EN=1): IDLE goes directly to DONE, so resp_valid is high in cycle 1.
  - Divisor==0: quotient=all ones; remainder=dividend.
  - Signed op with dividend=0x80000000 and divisor=0xFFFFFFFF: quotient=0x80000000; remainder=0.
  - With FAST_PATH_EN=0 these cases take the normal path and must produce the same values.
- Arithmetic:
  - Signed ops operate on magnitudes; unsigned ops use operands as-is.
  - Partial remainder is XLEN+1 bits. Each CALC cycle shifts in one dividend bit, trial-subtracts the divisor, and sets the quotient bit when the difference is non-negative.
  - FIX negates the quotient if the operand signs differ (DIV). It negates the remainder if the dividend is negative (REM). It then registers result.
- stall = (state==IDLE && req_valid && !flush) || state==CALC || state==FIX. stall is low in DONE so the instruction retires in the resp_valid cycle.
- resp_valid = (state==DONE) && !flush, registered as a state decode.
- flush has priority over everything:
  - In any state, the next state is IDLE and no resp_valid is produced for the killed op.
  - result is unchanged by a flush.
  - flush in IDLE with req_valid blocks acceptance.
- req_valid during CALC/FIX/DONE is ignored (req_ready=0).
- Reset:
  - state=IDLE, counter=0, result=0, internal registers=0.
  - Outputs: resp_valid=0, stall=0 (rst also masks the combinational term), req_ready=1 from the first cycle after rst falls.
  - rst mid-operation abandons the divide with no response.

Decomposition:
- PipelineTypes package gains:
  - DivOp enum, encoding equals funct3[1:0] of the M-extension divide opcodes.
  - DivState enum: IDLE, CALC, FIX, DONE.
  - DIV_ITER constant = XLEN.
- One sub-module, div_step: purely combinational single restoring iteration.
  - Inputs: partial remainder, divisor, next dividend bit.
  - Outputs: new partial remainder, quotient bit.
- The FSM, counter and sign fix-up stay in div_sequencer.

Test Plan:
1. DIVU 100/7 accepted in cycle 0 -> stall high cycles 0..33; resp_valid only in cycle 34; result=14. Repeat as REMU -> result=2.
2. DIV 0xFFFFFFF9(-7)/2 -> 0xFFFFFFFD(-3). REM -7/2 -> 0xFFFFFFFF(-1). REM 7/0xFFFFFFFE(-2) -> 1. All at cycle 34.
3. DIVU 0x12345678/0 -> 0xFFFFFFFF in cycle 1. REMU same operands -> 0x12345678 in cycle 1. With FAST_PATH_EN=0, same values in cycle 34.
4. DIV 0x80000000/0xFFFFFFFF -> 0x80000000 in cycle 1. REM same operands -> 0.
5. flush in cycle 10 (CALC) -> IDLE in cycle 11; no resp_valid; result keeps its old value. Then DIVU 9/3 accepted in cycle 11 -> resp_valid in cycle 45 with 3. flush coincident with DONE -> no resp_valid.
6. rst asserted in cycle 20 of a DIV -> the following cycle shows resp_valid=0, stall=0, req_ready=1, result=0. Back-to-back DIVU requests with req_valid held high -> second accepted in cycle 35, result at cycle 69.

Source files
------------

// File: rtl/div_sequencer_pkg.sv
// ============================================================================
//  Module   : div_sequencer_pkg
//  Purpose  : Shared types and constants for the execute-stage divide unit.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package div_sequencer_pkg;

    // Encoding matches funct3[1:0] of the M-extension divide opcodes
    typedef enum logic [1:0] {
        DIV_OP_DIV  = 2'b00,
        DIV_OP_DIVU = 2'b01,
        DIV_OP_REM  = 2'b10,
        DIV_OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        DS_IDLE = 2'd0,
        DS_CALC = 2'd1,
        DS_FIX  = 2'd2,
        DS_DONE = 2'd3
    } div_state_e;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam int DIV_ITER = 32;

    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

    function automatic logic op_is_rem(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

`default_nettype wire

// File: rtl/div_sequencer_div_step.sv
// ============================================================================
//  Module   : div_step
//  Purpose  : One combinational radix-2 restoring division iteration.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_rem,
    input  logic [XLEN-1:0] i_divisor,
    input  logic            i_bit,
    output logic [XLEN-1:0] o_rem,
    output logic            o_qbit
);

    logic [XLEN:0] w_shift;
    logic [XLEN:0] w_diff;

    // The shifted partial remainder is XLEN+1 bits; it is always below twice
    // the divisor, so the top bit of the difference is a true sign bit.
    assign w_shift = {i_rem, i_bit};
    assign w_diff  = w_shift - {1'b0, i_divisor};
    assign o_qbit  = ~w_diff[XLEN];
    assign o_rem   = o_qbit ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];

endmodule

`default_nettype wire

// File: rtl/div_sequencer.sv
// ============================================================================
//  Module   : div_sequencer
//  Purpose  : Multi-cycle RV32M DIV/DIVU/REM/REMU unit with stall and flush.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_sequencer
    import div_sequencer_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter bit FAST_PATH_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic            flush,
    output logic            stall,
    output logic            resp_valid,
    output logic [XLEN-1:0] result
);

    localparam int            c_CW   = $clog2(XLEN);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(XLEN - 1);

    logic [1:0]      r_state;
    logic [c_CW-1:0] r_cnt;
    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_quo;
    logic [XLEN-1:0] r_divisor;
    logic            r_neg_q;
    logic            r_neg_r;
    logic            r_is_rem;
    logic [XLEN-1:0] r_result;

    logic            w_accept;
    logic            w_signed;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [XLEN-1:0] w_a_mag;
    logic [XLEN-1:0] w_b_mag;
    logic            w_div_zero;
    logic            w_ovf;
    logic            w_fast;
    logic [XLEN-1:0] w_fast_res;
    logic [XLEN-1:0] w_step_rem;
    logic            w_step_q;
    logic [XLEN-1:0] w_q_fix;
    logic [XLEN-1:0] w_r_fix;

    assign w_accept   = (r_state == S_IDLE) && req_valid && !flush;
    assign w_signed   = op_is_signed(op);
    assign w_a_neg    = w_signed & dividend[XLEN-1];
    assign w_b_neg    = w_signed & divisor[XLEN-1];
    assign w_a_mag    = w_a_neg ? (~dividend + 1'b1) : dividend;
    assign w_b_mag    = w_b_neg ? (~divisor + 1'b1) : divisor;
    assign w_div_zero = (divisor == '0);
    assign w_ovf      = w_signed && (dividend == {1'b1, {(XLEN-1){1'b0}}})
                        && (divisor == '1);
    assign w_fast     = FAST_PATH_EN && (w_div_zero || w_ovf);

    // Divide-by-zero: quotient all ones, remainder is the dividend.
    // Overflow: quotient equals the dividend (most negative), remainder zero.
    always_comb begin
        w_fast_res = '0;
        if (op_is_rem(op)) begin
            w_fast_res = w_div_zero ? dividend : '0;
        end else begin
            w_fast_res = w_div_zero ? '1 : dividend;
        end
    end

    div_step #(
        .XLEN (XLEN)
    ) u_step (
        .i_rem     (r_rem),
        .i_divisor (r_divisor),
        .i_bit     (r_quo[XLEN-1]),
        .o_rem     (w_step_rem),
        .o_qbit    (w_step_q)
    );

    assign w_q_fix = r_neg_q ? (~r_quo + 1'b1) : r_quo;
    assign w_r_fix = r_neg_r ? (~r_rem + 1'b1) : r_rem;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_divisor <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_is_rem  <= 1'b0;
            r_result  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_cnt     <= '0;
                        r_rem     <= '0;
                        r_quo     <= w_a_mag;
                        r_divisor <= w_b_mag;
                        // A zero divisor keeps the all-ones quotient unsigned
                        r_neg_q   <= (w_a_neg ^ w_b_neg) & ~w_div_zero;
                        r_neg_r   <= w_a_neg;
                        r_is_rem  <= op_is_rem(op);
                        if (w_fast) begin
                            r_result <= w_fast_res;
                            r_state  <= S_DONE;
                        end else begin
                            r_state  <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    r_rem <= w_step_rem;
                    r_quo <= {r_quo[XLEN-2:0], w_step_q};
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_LAST) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (!flush) begin
                        r_result <= r_is_rem ? w_r_fix : w_q_fix;
                    end
                    r_state <= S_DONE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
            if (flush) begin
                r_state <= S_IDLE;
            end
        end
    end

    assign req_ready  = (r_state == S_IDLE);
    assign stall      = !rst && (w_accept || (r_state == S_CALC) || (r_state == S_FIX));
    assign resp_valid = (r_state == S_DONE) && !flush;
    assign result     = r_result;

endmodule

`default_nettype wire

// File: tb/tb_div_sequencer.sv
// ============================================================================
//  Module   : tb_div_sequencer
//  Purpose  : Scoreboard bench running a fast-path and an iterate-only divider
//             side by side on the same directed vectors.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_div_sequencer;

    typedef struct {
        logic [31:0] res;
        int          cyc;
    } exp_t;

    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic        req_valid = 1'b0;
    logic        flush     = 1'b0;
    logic [1:0]  op        = 2'b00;
    logic [31:0] dividend  = '0;
    logic [31:0] divisor   = '0;

    logic        a_ready, a_stall, a_rv;
    logic [31:0] a_res;
    logic        b_ready, b_stall, b_rv;
    logic [31:0] b_res;

    exp_t qa[$];
    exp_t qb[$];

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;

    int          tmo_req  = 0;
    int          tmo_ack  = 0;
    bit          trk_en   = 1'b0;
    int          trk_c0   = 0;
    bit          hold_en  = 1'b0;
    logic [31:0] hold_val = '0;
    bit          rst_chk  = 1'b0;
    bit          fin_chk  = 1'b0;
    bit          fin_done = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    div_sequencer #(.XLEN(32), .FAST_PATH_EN(1'b1)) u_fast (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(a_ready),
        .op(op), .dividend(dividend), .divisor(divisor), .flush(flush),
        .stall(a_stall), .resp_valid(a_rv), .result(a_res)
    );

    div_sequencer #(.XLEN(32), .FAST_PATH_EN(1'b0)) u_slow (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(b_ready),
        .op(op), .dividend(dividend), .divisor(divisor), .flush(flush),
        .stall(b_stall), .resp_valid(b_rv), .result(b_res)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every comparison happens here, on the falling edge
    initial begin
        exp_t e;
        int   k;
        forever begin
            @(negedge clk);
            if (a_rv) begin
                if (qa.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL fast_unexpected_resp: got resp_valid result %h, required no response (cycle %0d)", a_res, cyc);
                end else begin
                    e = qa.pop_front();
                    chk("fast_result", a_res, e.res);
                    chk("fast_resp_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
            if (b_rv) begin
                if (qb.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL slow_unexpected_resp: got resp_valid result %h, required no response (cycle %0d)", b_res, cyc);
                end else begin
                    e = qb.pop_front();
                    chk("slow_result", b_res, e.res);
                    chk("slow_resp_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
            if (trk_en) begin
                k = cyc - trk_c0;
                if (k >= 0 && k <= 34) begin
                    chk("fast_stall", 32'(a_stall), 32'(k <= 33));
                    chk("slow_stall", 32'(b_stall), 32'(k <= 33));
                    chk("fast_req_ready", 32'(a_ready), 32'(k == 0));
                    chk("slow_req_ready", 32'(b_ready), 32'(k == 0));
                end
            end
            if (hold_en) begin
                chk("fast_result_hold", a_res, hold_val);
                chk("slow_result_hold", b_res, hold_val);
            end
            if (rst_chk) begin
                chk("fast_rst_resp_valid", 32'(a_rv), 32'd0);
                chk("fast_rst_stall", 32'(a_stall), 32'd0);
                chk("fast_rst_req_ready", 32'(a_ready), 32'd1);
                chk("fast_rst_result", a_res, 32'd0);
                chk("slow_rst_resp_valid", 32'(b_rv), 32'd0);
                chk("slow_rst_stall", 32'(b_stall), 32'd0);
                chk("slow_rst_req_ready", 32'(b_ready), 32'd1);
                chk("slow_rst_result", b_res, 32'd0);
            end
            if (tmo_req != tmo_ack) begin
                n_cmp++; n_bad++;
                $display("FAIL response_timeout: got no response within budget, required pending responses (cycle %0d)", cyc);
                tmo_ack = tmo_req;
            end
            if (fin_chk && !fin_done) begin
                chk("fast_pending_left", 32'(qa.size()), 32'd0);
                chk("slow_pending_left", 32'(qb.size()), 32'd0);
                fin_done = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((qa.size() != 0 || qb.size() != 0) && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (qa.size() != 0 || qb.size() != 0) begin
            tmo_req++;
            qa.delete();
            qb.delete();
        end
        tick();
    endtask

    // Called just after a rising edge with both units idle
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input bit fast);
        int c0;
        c0        = cyc;
        op        = o;
        dividend  = a;
        divisor   = b;
        req_valid = 1'b1;
        qa.push_back('{exp, c0 + (fast ? 1 : 34)});
        qb.push_back('{exp, c0 + 34});
        tick();
        req_valid = 1'b0;
        wait_drain();
    endtask

    initial begin
        int c0;
        rst = 1'b1;
        repeat (3) tick();
        rst     = 1'b0;
        rst_chk = 1'b1;
        tick();
        rst_chk = 1'b0;
        tick();

        // Basic unsigned, with the stall/req_ready profile tracked
        trk_c0 = cyc;
        trk_en = 1'b1;
        issue(2'b01, 32'd100, 32'd7, 32'd14, 1'b0);
        trk_en = 1'b0;
        issue(2'b11, 32'd100, 32'd7, 32'd2, 1'b0);

        // Signed sign fix-up
        issue(2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0);
        issue(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0);
        issue(2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 1'b0);
        issue(2'b00, 32'h8000_0000, 32'd3, 32'hD555_5556, 1'b0);
        issue(2'b10, 32'h8000_0000, 32'd3, 32'hFFFF_FFFE, 1'b0);

        // Divide by zero
        issue(2'b01, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 1'b1);
        issue(2'b11, 32'h1234_5678, 32'd0, 32'h1234_5678, 1'b1);
        issue(2'b00, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 1'b1);
        issue(2'b10, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 1'b1);

        // Signed overflow, and the same operands unsigned
        issue(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b1);
        issue(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0);
        issue(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
        issue(2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 1'b0);

        // Flush during CALC: killed op, result held, next op in cycle 11
        c0        = cyc;
        hold_val  = 32'hFFFF_FFFF;
        hold_en   = 1'b1;
        op        = 2'b01;
        dividend  = 32'd1000;
        divisor   = 32'd3;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush     = 1'b0;
        op        = 2'b01;
        dividend  = 32'd9;
        divisor   = 32'd3;
        req_valid = 1'b1;
        qa.push_back('{32'd3, c0 + 45});
        qb.push_back('{32'd3, c0 + 45});
        tick();
        req_valid = 1'b0;
        repeat (33) tick();
        hold_en = 1'b0;
        wait_drain();

        // Flush coincident with DONE suppresses the response
        op        = 2'b01;
        dividend  = 32'd50;
        divisor   = 32'd5;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        repeat (33) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        repeat (3) tick();

        // Reset in cycle 20 of a DIV
        op        = 2'b00;
        dividend  = 32'hFFFF_FF00;
        divisor   = 32'd7;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        repeat (19) tick();
        rst = 1'b1;
        tick();
        rst     = 1'b0;
        rst_chk = 1'b1;
        tick();
        rst_chk = 1'b0;
        repeat (40) tick();

        // Back-to-back with req_valid held high
        c0        = cyc;
        op        = 2'b01;
        dividend  = 32'd20;
        divisor   = 32'd4;
        req_valid = 1'b1;
        qa.push_back('{32'd5, c0 + 34});
        qb.push_back('{32'd5, c0 + 34});
        tick();
        dividend  = 32'd100;
        divisor   = 32'd10;
        qa.push_back('{32'd10, c0 + 69});
        qb.push_back('{32'd10, c0 + 69});
        repeat (35) tick();
        req_valid = 1'b0;
        wait_drain();

        fin_chk = 1'b1;
        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
